// File: rtl/mesh_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mesh_pkg : shared mesh defaults, FSM state encoding and tile-index width helper
// Rev 1.0
// ============================================================================
package mesh_pkg;

    localparam int MESH_ADDRESS_SIZE = 10;
    localparam int MESH_DATA_SIZE    = 8;
    localparam int MESH_NB_TILES     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mesh_state_e;

    // A single tile needs no index bits at all.
    function automatic int tile_index_width(input int nb_tiles);
        return (nb_tiles <= 1) ? 0 : $clog2(nb_tiles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_tile_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mesh_tile_decode : tile index -> one-hot select plus in-range flag (combinational)
// Rev 1.0
// ============================================================================
module mesh_tile_decode
    import mesh_pkg::*;
#(
    parameter int NB_TILES = MESH_NB_TILES,
    parameter int IDX_W    = 1
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [NB_TILES-1:0] one_hot,
    output logic                in_range
);

    always_comb begin
        one_hot  = '0;
        for (int i = 0; i < NB_TILES; i++) begin
            one_hot[i] = (32'(idx) == 32'(i));
        end
        // Non-power-of-two arrays leave index codes with no tile behind them.
        in_range = (32'(idx) < 32'(NB_TILES));
    end

endmodule
`default_nettype wire

// File: rtl/mesh_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mesh_readback : reads one word back from the tile addressed by a global address.
// Optional READBACK_TIMEOUT_EN bounds the wait for a tile acknowledge.  Rev 1.0
// ============================================================================
module mesh_readback
    import mesh_pkg::*;
#(
    parameter  int ADDRESS_SIZE   = MESH_ADDRESS_SIZE,
    parameter  int DATA_SIZE      = MESH_DATA_SIZE,
    parameter  int NB_TILES       = MESH_NB_TILES,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int TILE_W         = tile_index_width(NB_TILES),
    localparam int LOCAL_W        = ADDRESS_SIZE - TILE_W
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic [ADDRESS_SIZE-1:0]       ADDRESS,
    output logic [NB_TILES-1:0]           SELECT_TILE,
    output logic [LOCAL_W-1:0]            ADDRESS_TILE,
    input  logic [NB_TILES-1:0]           TILE_ACK,
    input  logic [NB_TILES*DATA_SIZE-1:0] TILE_DATA,
    output logic [DATA_SIZE-1:0]          DATA_OUT,
    output logic                          DATA_VALID,
    output logic                          ERROR
);

    localparam int IDX_W = (TILE_W > 0) ? TILE_W : 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    if (TIMEOUT_CYCLES < 1 || NB_TILES < 1 || TILE_W >= ADDRESS_SIZE) begin : g_param_check
        $error("mesh_readback: illegal parameterisation");
    end

    logic [1:0]           state;
    logic                 req_ready;
    logic [NB_TILES-1:0]  select;
    logic [LOCAL_W-1:0]   addr_tile;
    logic [DATA_SIZE-1:0] data_out;
    logic                 data_valid;
    logic                 error;

    logic [IDX_W-1:0]     req_idx;
    logic [LOCAL_W-1:0]   req_local;
    logic [NB_TILES-1:0]  idx_one_hot;
    logic                 idx_in_range;
    logic                 ack_hit;
    logic [DATA_SIZE-1:0] ack_data;

    // With one tile there are no index bits and the whole address is local.
    if (TILE_W == 0) begin : g_single_tile
        assign req_idx   = '0;
        assign req_local = ADDRESS;
    end else begin : g_multi_tile
        assign req_idx   = ADDRESS[ADDRESS_SIZE-1 -: TILE_W];
        assign req_local = ADDRESS[LOCAL_W-1:0];
    end

    mesh_tile_decode #(
        .NB_TILES (NB_TILES),
        .IDX_W    (IDX_W)
    ) u_tile_decode (
        .idx      (req_idx),
        .one_hot  (idx_one_hot),
        .in_range (idx_in_range)
    );

    // The held one-hot select masks both the acknowledge and the data slice.
    assign ack_hit = |(TILE_ACK & select);

    always_comb begin
        ack_data = '0;
        for (int i = 0; i < NB_TILES; i++) begin
            if (select[i]) begin
                ack_data = TILE_DATA[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

`ifdef READBACK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_count;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            select     <= '0;
            addr_tile  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
`ifdef READBACK_TIMEOUT_EN
            wait_count <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (REQ_VALID && req_ready) begin
                        req_ready <= 1'b0;
                        if (idx_in_range) begin
                            select    <= idx_one_hot;
                            addr_tile <= req_local;
                            state     <= S_ISSUE;
                        end else begin
                            data_out   <= '0;
                            error      <= 1'b1;
                            data_valid <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                // Acknowledges seen while the select is first presented are ignored.
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef READBACK_TIMEOUT_EN
                    wait_count <= '0;
`endif
                end
                S_WAIT: begin
                    if (ack_hit) begin
                        data_out   <= ack_data;
                        error      <= 1'b0;
                        select     <= '0;
                        data_valid <= 1'b1;
                        state      <= S_RESP;
                    end
`ifdef READBACK_TIMEOUT_EN
                    else if (wait_count == WAIT_LAST) begin
                        data_out   <= '0;
                        error      <= 1'b1;
                        select     <= '0;
                        data_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wait_count <= wait_count + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign REQ_READY    = req_ready;
    assign SELECT_TILE  = select;
    assign ADDRESS_TILE = addr_tile;
    assign DATA_OUT     = data_out;
    assign DATA_VALID   = data_valid;
    assign ERROR        = error;

endmodule
`default_nettype wire

// File: tb/tb_mesh_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mesh_readback : directed checks of mesh_readback (4-tile and 3-tile instances)
// Rev 1.0
// ============================================================================
module tb_mesh_readback;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET;

    logic        req_valid;
    logic        req_ready;
    logic [9:0]  address;
    logic [3:0]  select_tile;
    logic [7:0]  address_tile;
    logic [3:0]  tile_ack;
    logic [31:0] tile_data;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        error;

    logic        req_valid3;
    logic        req_ready3;
    logic [9:0]  address3;
    logic [2:0]  select_tile3;
    logic [7:0]  address_tile3;
    logic [2:0]  tile_ack3;
    logic [23:0] tile_data3;
    logic [7:0]  data_out3;
    logic        data_valid3;
    logic        error3;

    int checks = 0;
    int errors = 0;

    mesh_readback #(
        .ADDRESS_SIZE   (10),
        .DATA_SIZE      (8),
        .NB_TILES       (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ_VALID    (req_valid),
        .REQ_READY    (req_ready),
        .ADDRESS      (address),
        .SELECT_TILE  (select_tile),
        .ADDRESS_TILE (address_tile),
        .TILE_ACK     (tile_ack),
        .TILE_DATA    (tile_data),
        .DATA_OUT     (data_out),
        .DATA_VALID   (data_valid),
        .ERROR        (error)
    );

    mesh_readback #(
        .ADDRESS_SIZE   (10),
        .DATA_SIZE      (8),
        .NB_TILES       (3),
        .TIMEOUT_CYCLES (16)
    ) dut3 (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ_VALID    (req_valid3),
        .REQ_READY    (req_ready3),
        .ADDRESS      (address3),
        .SELECT_TILE  (select_tile3),
        .ADDRESS_TILE (address_tile3),
        .TILE_ACK     (tile_ack3),
        .TILE_DATA    (tile_data3),
        .DATA_OUT     (data_out3),
        .DATA_VALID   (data_valid3),
        .ERROR        (error3)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic seen_valid;

    initial begin
        RESET      = 1'b0;
        req_valid  = 1'b0;
        address    = '0;
        tile_ack   = '0;
        tile_data  = '0;
        req_valid3 = 1'b0;
        address3   = '0;
        tile_ack3  = '0;
        tile_data3 = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready",  req_ready,    1'b0);
        chk("rst_select", select_tile,  4'b0000);
        chk("rst_addr",   address_tile, 8'h00);
        chk("rst_data",   data_out,     8'h00);
        chk("rst_valid",  data_valid,   1'b0);
        chk("rst_error",  error,        1'b0);
        RESET = 1'b1;
        tick();
        chk("ready_after_rst", req_ready, 1'b1);

        // Tile 2 read, with a foreign ACK from tile 1 in the middle
        address   = 10'h2A5;
        req_valid = 1'b1;
        tile_data = 32'h005C_FF00;
        tick();                             // ISSUE
        req_valid = 1'b0;
        chk("t1_select",     select_tile,  4'b0100);
        chk("t1_addr",       address_tile, 8'hA5);
        chk("t1_ready_busy", req_ready,    1'b0);
        tick();                             // WAIT 1
        tile_ack = 4'b0010;
        tick();                             // WAIT 2
        tile_ack = 4'b0000;
        chk("t2_foreign_ack_valid", data_valid,  1'b0);
        chk("t2_select_held",       select_tile, 4'b0100);
        tick();                             // WAIT 3
        tile_ack = 4'b0100;
        tick();                             // RESP
        tile_ack = 4'b0000;
        chk("t1_valid",      data_valid,   1'b1);
        chk("t1_data",       data_out,     8'h5C);
        chk("t1_error",      error,        1'b0);
        chk("t1_select_clr", select_tile,  4'b0000);
        chk("t1_addr_kept",  address_tile, 8'hA5);
        tick();
        chk("t1_valid_pulse", data_valid, 1'b0);
        chk("t1_data_hold",   data_out,   8'h5C);
        chk("t1_ready_back",  req_ready,  1'b1);

        // Out-of-range index on the 3-tile instance
        address3   = 10'h3C0;
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        chk("t3_valid",  data_valid3,  1'b1);
        chk("t3_error",  error3,       1'b1);
        chk("t3_data",   data_out3,    8'h00);
        chk("t3_select", select_tile3, 3'b000);
        chk("t3_ready",  req_ready3,   1'b0);
        tick();
        chk("t3_valid_pulse", data_valid3,  1'b0);
        chk("t3_select_idle", select_tile3, 3'b000);
        chk("t3_ready_back",  req_ready3,   1'b1);

        // Long wait on tile 0
        address   = 10'h0C3;
        req_valid = 1'b1;
        tile_data = 32'h0000_003A;
        tick();                             // ISSUE
        req_valid = 1'b0;
        chk("t4_select", select_tile,  4'b0001);
        chk("t4_addr",   address_tile, 8'hC3);
        seen_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();                         // WAIT cycles 1..16
            if (data_valid) seen_valid = 1'b1;
        end
        chk("t4_wait_quiet", seen_valid, 1'b0);
`ifdef READBACK_TIMEOUT_EN
        tick();
        chk("t4_to_valid",  data_valid,  1'b1);
        chk("t4_to_error",  error,       1'b1);
        chk("t4_to_data",   data_out,    8'h00);
        chk("t4_to_select", select_tile, 4'b0000);
        tick();
        address   = 10'h0C3;
        req_valid = 1'b1;
        tick();                             // ISSUE
        req_valid = 1'b0;
        repeat (16) tick();                 // 16th WAIT cycle
        tile_ack = 4'b0001;
        tick();
        tile_ack = 4'b0000;
        chk("t4_late_ack_valid", data_valid, 1'b1);
        chk("t4_late_ack_error", error,      1'b0);
        chk("t4_late_ack_data",  data_out,   8'h3A);
        tick();
`else
        tick();
        chk("t4_no_timeout_valid",  data_valid,  1'b0);
        chk("t4_no_timeout_select", select_tile, 4'b0001);
        repeat (10) tick();
        chk("t4_still_waiting", select_tile, 4'b0001);
        tile_ack = 4'b0001;
        tick();
        tile_ack = 4'b0000;
        chk("t4_ack_valid", data_valid, 1'b1);
        chk("t4_ack_error", error,      1'b0);
        chk("t4_ack_data",  data_out,   8'h3A);
        tick();
`endif

        // Reset while waiting on tile 1
        chk("t5_ready_pre", req_ready, 1'b1);
        address   = 10'h1AB;
        req_valid = 1'b1;
        tile_data = 32'h0000_2277;
        tick();                             // ISSUE
        req_valid = 1'b0;
        tick();                             // WAIT
        RESET = 1'b0;
        tick();
        chk("t5_rst_select", select_tile,  4'b0000);
        chk("t5_rst_addr",   address_tile, 8'h00);
        chk("t5_rst_data",   data_out,     8'h00);
        chk("t5_rst_valid",  data_valid,   1'b0);
        chk("t5_rst_error",  error,        1'b0);
        chk("t5_rst_ready",  req_ready,    1'b0);
        RESET = 1'b1;
        tick();
        chk("t5_ready_after", req_ready,  1'b1);
        chk("t5_no_stale",    data_valid, 1'b0);
        address   = 10'h011;
        req_valid = 1'b1;
        tick();                             // ISSUE
        req_valid = 1'b0;
        chk("t5_select", select_tile,  4'b0001);
        chk("t5_addr",   address_tile, 8'h11);
        tick();                             // WAIT
        tile_ack = 4'b0001;
        tick();
        tile_ack = 4'b0000;
        chk("t5_valid", data_valid, 1'b1);
        chk("t5_data",  data_out,   8'h77);
        chk("t5_error", error,      1'b0);
        tick();

        // Back-to-back requests with REQ_VALID held high
        tile_data = 32'h3300_1100;
        tile_ack  = 4'b1010;
        address   = 10'h100;
        req_valid = 1'b1;
        tick();                             // ISSUE #1
        address = 10'h3FF;
        chk("t6_sel1",   select_tile,  4'b0010);
        chk("t6_addr1",  address_tile, 8'h00);
        chk("t6_busy1a", req_ready,    1'b0);
        tick();                             // WAIT #1
        chk("t6_busy1b", req_ready, 1'b0);
        tick();                             // RESP #1
        chk("t6_valid1", data_valid, 1'b1);
        chk("t6_data1",  data_out,   8'h11);
        chk("t6_busy1c", req_ready,  1'b0);
        tick();                             // IDLE, accept #2
        chk("t6_ready_gap", req_ready,  1'b1);
        chk("t6_gap_valid", data_valid, 1'b0);
        tick();                             // ISSUE #2
        req_valid = 1'b0;
        chk("t6_sel2",  select_tile,  4'b1000);
        chk("t6_addr2", address_tile, 8'hFF);
        chk("t6_busy2", req_ready,    1'b0);
        tick();                             // WAIT #2
        tick();                             // RESP #2
        chk("t6_valid2", data_valid, 1'b1);
        chk("t6_data2",  data_out,   8'h33);
        chk("t6_error2", error,      1'b0);
        tile_ack = 4'b0000;
        tick();
        chk("t6_end_valid", data_valid, 1'b0);
        chk("t6_end_ready", req_ready,  1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
